// File: rtl/tick_gen.sv
// Multi-channel timebase: a shared prescaler drives NUM_CH programmable
// periodic or one-shot tick channels, all aligned to the base tick.
module tick_gen #(
    parameter int PRESCALE = 50,
    parameter int PRE_W    = 16,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int CH_W     = 4
) (
    input  logic              pll_outclk_0,
    input  logic              rst,
    input  logic              hold,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_en,
    input  logic              cfg_oneshot,
    output logic              base_tck,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]  pre_cnt_r;
    logic [PRE_W-1:0]  pre_cnt_nx_s;
    logic              wrap_s;

    logic [CNT_W-1:0]  period_r    [NUM_CH];
    logic [CNT_W-1:0]  period_nx_s [NUM_CH];
    logic [CNT_W-1:0]  cnt_r       [NUM_CH];
    logic [CNT_W-1:0]  cnt_nx_s    [NUM_CH];
    logic [NUM_CH-1:0] en_r;
    logic [NUM_CH-1:0] en_nx_s;
    logic [NUM_CH-1:0] os_r;
    logic [NUM_CH-1:0] os_nx_s;
    logic [NUM_CH-1:0] tick_nx_s;
    logic [NUM_CH-1:0] busy_nx_s;
    logic [NUM_CH-1:0] wr_hit_s;

    // Prescaler next state; the wrap strobe is the internal base-tick event.
    always_comb begin
        pre_cnt_nx_s = pre_cnt_r;
        wrap_s       = 1'b0;
        if (hold) begin
            pre_cnt_nx_s = pre_cnt_r;
            wrap_s       = 1'b0;
        end else if (pre_cnt_r == PRE_LAST) begin
            pre_cnt_nx_s = '0;
            wrap_s       = 1'b1;
        end else begin
            pre_cnt_nx_s = pre_cnt_r + PRE_W'(1);
        end
    end

    // Channel next state; a config write beats a coincident terminal event.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            period_nx_s[i] = period_r[i];
            cnt_nx_s[i]    = cnt_r[i];
            en_nx_s[i]     = en_r[i];
            os_nx_s[i]     = os_r[i];
            tick_nx_s[i]   = 1'b0;
            wr_hit_s[i]    = cfg_wr && (cfg_ch == CH_W'(i));
            if (wr_hit_s[i]) begin
                period_nx_s[i] = cfg_period;
                cnt_nx_s[i]    = '0;
                en_nx_s[i]     = cfg_en;
                os_nx_s[i]     = cfg_oneshot;
            end else if (wrap_s && en_r[i] && (period_r[i] != '0)) begin
                if (cnt_r[i] == period_r[i] - CNT_W'(1)) begin
                    cnt_nx_s[i]  = '0;
                    tick_nx_s[i] = 1'b1;
                    if (os_r[i]) begin
                        en_nx_s[i] = 1'b0;
                    end else begin
                        en_nx_s[i] = en_r[i];
                    end
                end else begin
                    cnt_nx_s[i] = cnt_r[i] + CNT_W'(1);
                end
            end else begin
                cnt_nx_s[i] = cnt_r[i];
            end
            busy_nx_s[i] = en_nx_s[i] && (period_nx_s[i] != '0);
        end
    end

    // State and registered outputs; reset overrides hold and config writes.
    always_ff @(posedge pll_outclk_0) begin
        if (!rst) begin
            pre_cnt_r <= '0;
            base_tck  <= 1'b0;
            tick      <= '0;
            busy      <= '0;
            en_r      <= '0;
            os_r      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                period_r[i] <= '0;
                cnt_r[i]    <= '0;
            end
        end else begin
            pre_cnt_r <= pre_cnt_nx_s;
            base_tck  <= wrap_s;
            tick      <= tick_nx_s;
            busy      <= busy_nx_s;
            en_r      <= en_nx_s;
            os_r      <= os_nx_s;
            for (int i = 0; i < NUM_CH; i++) begin
                period_r[i] <= period_nx_s[i];
                cnt_r[i]    <= cnt_nx_s[i];
            end
        end
    end

endmodule
